// File: rtl/reg_file_hilo_if.sv
// Write-back to decode register-file bus: GPR and HI/LO write side plus the decode read ports.
// The master drives writes and read addresses. The slave is the register file, which returns read data.
interface reg_file_hilo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  reg_write_en_w;
    logic [ADDR_WIDTH-1:0] reg_file_write_addr_w;
    logic [DATA_WIDTH-1:0] reg_file_write_data_w;
    logic                  hilo_write_en_w;
    logic [DATA_WIDTH-1:0] hi_write_data_w;
    logic [DATA_WIDTH-1:0] lo_write_data_w;
    logic [ADDR_WIDTH-1:0] read_addr_1_d;
    logic [ADDR_WIDTH-1:0] read_addr_2_d;
    logic [DATA_WIDTH-1:0] read_data_1_d;
    logic [DATA_WIDTH-1:0] read_data_2_d;
    logic [DATA_WIDTH-1:0] hi_read_data_d;
    logic [DATA_WIDTH-1:0] lo_read_data_d;

    modport master (
        output reg_write_en_w, reg_file_write_addr_w, reg_file_write_data_w,
        output hilo_write_en_w, hi_write_data_w, lo_write_data_w,
        output read_addr_1_d, read_addr_2_d,
        input  read_data_1_d, read_data_2_d, hi_read_data_d, lo_read_data_d
    );

    modport slave (
        input  reg_write_en_w, reg_file_write_addr_w, reg_file_write_data_w,
        input  hilo_write_en_w, hi_write_data_w, lo_write_data_w,
        input  read_addr_1_d, read_addr_2_d,
        output read_data_1_d, read_data_2_d, hi_read_data_d, lo_read_data_d
    );
endinterface

// File: rtl/reg_file_hilo.sv
// Decode-stage GPR file with HI/LO. Reads are combinational with zero latency, and an optional write-to-read bypass is provided.
// Writes commit on the next rising edge. There is no backpressure: a write is accepted every cycle.
module reg_file_hilo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS_EN  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_file_hilo_if.slave bus
);
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam bit BYP  = (BYPASS_EN != 0);

    logic [DATA_WIDTH-1:0] gpr_q [1:NREG-1];
    logic [DATA_WIDTH-1:0] gpr_d [1:NREG-1];
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic gpr_wr, bypass_on;

    assign gpr_wr    = bus.reg_write_en_w && (bus.reg_file_write_addr_w != '0);
    assign bypass_on = BYP && rst_n;

    always_comb begin
        gpr_d = gpr_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (gpr_wr) begin
            gpr_d[bus.reg_file_write_addr_w] = bus.reg_file_write_data_w;
        end
        if (bus.hilo_write_en_w) begin
            hi_d = bus.hi_write_data_w;
            lo_d = bus.lo_write_data_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            gpr_q <= gpr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    // r0 is never stored and never bypassed; a matching write only counts when it targets a real register.
    always_comb begin
        bus.read_data_1_d = '0;
        if (bus.read_addr_1_d != '0) begin
            if (bypass_on && gpr_wr && (bus.reg_file_write_addr_w == bus.read_addr_1_d)) begin
                bus.read_data_1_d = bus.reg_file_write_data_w;
            end else begin
                bus.read_data_1_d = gpr_q[bus.read_addr_1_d];
            end
        end
    end

    always_comb begin
        bus.read_data_2_d = '0;
        if (bus.read_addr_2_d != '0) begin
            if (bypass_on && gpr_wr && (bus.reg_file_write_addr_w == bus.read_addr_2_d)) begin
                bus.read_data_2_d = bus.reg_file_write_data_w;
            end else begin
                bus.read_data_2_d = gpr_q[bus.read_addr_2_d];
            end
        end
    end

    always_comb begin
        bus.hi_read_data_d = hi_q;
        bus.lo_read_data_d = lo_q;
        if (bypass_on && bus.hilo_write_en_w) begin
            bus.hi_read_data_d = bus.hi_write_data_w;
            bus.lo_read_data_d = bus.lo_write_data_w;
        end
    end
endmodule

// File: tb/tb_reg_file_hilo.sv
// Directed bench for reg_file_hilo, with one bypassing instance and one non-bypassing instance driven in lockstep.
module tb_reg_file_hilo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, hwe;
    logic [4:0]  waddr, ra1, ra2;
    logic [31:0] wdata, hdata, ldata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_hilo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_b ();
    reg_file_hilo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_n ();

    assign bus_b.reg_write_en_w        = we;
    assign bus_b.reg_file_write_addr_w = waddr;
    assign bus_b.reg_file_write_data_w = wdata;
    assign bus_b.hilo_write_en_w       = hwe;
    assign bus_b.hi_write_data_w       = hdata;
    assign bus_b.lo_write_data_w       = ldata;
    assign bus_b.read_addr_1_d         = ra1;
    assign bus_b.read_addr_2_d         = ra2;
    assign bus_n.reg_write_en_w        = we;
    assign bus_n.reg_file_write_addr_w = waddr;
    assign bus_n.reg_file_write_data_w = wdata;
    assign bus_n.hilo_write_en_w       = hwe;
    assign bus_n.hi_write_data_w       = hdata;
    assign bus_n.lo_write_data_w       = ldata;
    assign bus_n.read_addr_1_d         = ra1;
    assign bus_n.read_addr_2_d         = ra2;

    reg_file_hilo #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    reg_file_hilo #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(0)) u_dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then give inputs a moment after it to settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; hwe = 1'b0;
        waddr = '0; wdata = '0; hdata = '0; ldata = '0;
        ra1 = '0; ra2 = '0;

        // Reset held for two edges.
        tick(); tick();
        ra1 = 5'd0; ra2 = 5'd5; settle();
        check("rst_r0", bus_b.read_data_1_d, 32'h0);
        check("rst_r5", bus_b.read_data_2_d, 32'h0);
        ra1 = 5'd31; settle();
        check("rst_r31", bus_b.read_data_1_d, 32'h0);
        check("rst_hi", bus_b.hi_read_data_d, 32'h0);
        check("rst_lo", bus_b.lo_read_data_d, 32'h0);
        check("rst_nb_r31", bus_n.read_data_1_d, 32'h0);
        rst_n = 1'b1;

        // Write, then read on the following cycle.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0; ra1 = 5'd5; ra2 = 5'd6; settle();
        check("wr_r5", bus_b.read_data_1_d, 32'hDEADBEEF);
        check("wr_r6", bus_b.read_data_2_d, 32'h0);
        check("wr_nb_r5", bus_n.read_data_1_d, 32'hDEADBEEF);

        // Same-cycle bypass on both ports.
        we = 1'b1; waddr = 5'd9; wdata = 32'h12345678; ra1 = 5'd9; ra2 = 5'd9; settle();
        check("byp_p1", bus_b.read_data_1_d, 32'h12345678);
        check("byp_p2", bus_b.read_data_2_d, 32'h12345678);
        check("nb_pre_p1", bus_n.read_data_1_d, 32'h0);
        check("nb_pre_p2", bus_n.read_data_2_d, 32'h0);
        tick();
        we = 1'b0; settle();
        check("byp_post_p1", bus_b.read_data_1_d, 32'h12345678);
        check("byp_post_p2", bus_b.read_data_2_d, 32'h12345678);
        check("nb_post_p1", bus_n.read_data_1_d, 32'h12345678);
        check("nb_post_p2", bus_n.read_data_2_d, 32'h12345678);

        // A write to r0 must never show.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0; settle();
        check("r0_same_p1", bus_b.read_data_1_d, 32'h0);
        check("r0_same_p2", bus_b.read_data_2_d, 32'h0);
        tick();
        we = 1'b0; settle();
        check("r0_next_p1", bus_b.read_data_1_d, 32'h0);
        check("r0_next_nb", bus_n.read_data_1_d, 32'h0);

        // HI/LO and GPR written in the same cycle.
        hwe = 1'b1; hdata = 32'h00000001; ldata = 32'h80000000;
        we = 1'b1; waddr = 5'd31; wdata = 32'hCAFEF00D; ra1 = 5'd31; ra2 = 5'd5; settle();
        check("hl_byp_r31", bus_b.read_data_1_d, 32'hCAFEF00D);
        check("hl_byp_hi", bus_b.hi_read_data_d, 32'h00000001);
        check("hl_byp_lo", bus_b.lo_read_data_d, 32'h80000000);
        check("hl_byp_r5", bus_b.read_data_2_d, 32'hDEADBEEF);
        check("hl_nb_hi", bus_n.hi_read_data_d, 32'h0);
        check("hl_nb_r31", bus_n.read_data_1_d, 32'h0);
        tick();
        hwe = 1'b0; we = 1'b0; settle();
        check("hl_st_r31", bus_b.read_data_1_d, 32'hCAFEF00D);
        check("hl_st_hi", bus_b.hi_read_data_d, 32'h00000001);
        check("hl_st_lo", bus_b.lo_read_data_d, 32'h80000000);
        check("hl_nb_st_lo", bus_n.lo_read_data_d, 32'h80000000);
        hdata = 32'hDDDDDDDD; ldata = 32'hEEEEEEEE;
        we = 1'b1; waddr = 5'd3; wdata = 32'h00000033; ra1 = 5'd3; settle();
        check("hl_hold_hi_pre", bus_b.hi_read_data_d, 32'h00000001);
        check("hl_r3_byp", bus_b.read_data_1_d, 32'h00000033);
        tick();
        we = 1'b0; settle();
        check("hl_hold_hi", bus_b.hi_read_data_d, 32'h00000001);
        check("hl_hold_lo", bus_b.lo_read_data_d, 32'h80000000);
        check("hl_r3", bus_b.read_data_1_d, 32'h00000033);

        // Reset in the same cycle as a write: the write is lost and there is no bypass.
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        tick();
        rst_n = 1'b0; we = 1'b1; waddr = 5'd7; wdata = 32'h11111111; ra1 = 5'd7; ra2 = 5'd7; settle();
        check("rc_pre_p1", bus_b.read_data_1_d, 32'hA5A5A5A5);
        check("rc_pre_nb", bus_n.read_data_2_d, 32'hA5A5A5A5);
        tick();
        rst_n = 1'b1; we = 1'b0; settle();
        check("rc_post_r7", bus_b.read_data_1_d, 32'h0);
        check("rc_post_nb", bus_n.read_data_1_d, 32'h0);
        ra1 = 5'd31; settle();
        check("rc_post_r31", bus_b.read_data_1_d, 32'h0);
        check("rc_post_hi", bus_b.hi_read_data_d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_hilo.md
Name: reg_file_hilo

Overview:
- Decode-stage register file for the pipelined MIPS core. It is the consumer end of the write-back interface.
- Accepts the write-back stage's selected write data, write address and enables, plus the HI/LO results.
- Serves two architectural read ports and HI/LO read ports to decode.
- Internal write-to-read bypass gives same-cycle write-before-read semantics, so decode sees a value being written back in the same cycle.

Parameters:
- DATA_WIDTH, 32, width of every register and data port.
- ADDR_WIDTH, 5, register address width; register count = 2**ADDR_WIDTH.
- BYPASS_EN, 1, 1 = write-to-read bypass on all read ports; 0 = reads return stored contents only.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- reg_write_en_w  input  1  GPR write enable from write-back.
- reg_file_write_addr_w  input  ADDR_WIDTH  GPR write address.
- reg_file_write_data_w  input  DATA_WIDTH  GPR write data (write-back mux output).
- hilo_write_en_w  input  1  HI and LO write enable, written together.
- hi_write_data_w  input  DATA_WIDTH  new HI value.
- lo_write_data_w  input  DATA_WIDTH  new LO value.
- read_addr_1_d  input  ADDR_WIDTH  read port 1 address (rs).
- read_addr_2_d  input  ADDR_WIDTH  read port 2 address (rt).
- read_data_1_d  output  DATA_WIDTH  read port 1 data.
- read_data_2_d  output  DATA_WIDTH  read port 2 data.
- hi_read_data_d  output  DATA_WIDTH  HI data.
- lo_read_data_d  output  DATA_WIDTH  LO data.

Behaviour:
- Storage
  - Registers 1..2**ADDR_WIDTH-1 plus HI and LO.
  - Register 0 is hardwired to zero: never stored, always reads 0, and is never bypassed.
- Reset
  - When rst_n=0 at a rising clk edge, all GPRs, HI and LO are set to 0.
  - Reset dominates any write in that same cycle.
  - While rst_n=0, the bypass is suppressed and reads return stored contents.
  - Net effect: all outputs read 0 from the first edge after rst_n is sampled low.
  - Reset mid-stream discards any write presented in the reset cycle.
- GPR write
  - At a rising edge with rst_n=1, reg_write_en_w=1 and reg_file_write_addr_w!=0, the register at that address takes reg_file_write_data_w.
  - A write to address 0 is ignored.
- HI/LO write
  - At a rising edge with rst_n=1 and hilo_write_en_w=1, HI takes hi_write_data_w and LO takes lo_write_data_w.
  - This path is independent of the GPR write; both may occur in the same cycle.
- Reads
  - Combinational from addresses to data; zero-cycle latency.
  - read_data_n = 0 if read_addr_n = 0.
  - read_data_n = reg_file_write_data_w if BYPASS_EN=1, rst_n=1, reg_write_en_w=1, and reg_file_write_addr_w = read_addr_n.
  - Otherwise read_data_n = the stored register.
  - HI/LO reads return the incoming write data when BYPASS_EN=1, rst_n=1 and hilo_write_en_w=1; otherwise they return the stored values.
  - Both read ports may address the same register, including the one being written; both then return identical data.
- With BYPASS_EN=0, a write becomes visible on the cycle after the write edge.
- No stalls or handshakes: writes complete in one cycle and a write is accepted every cycle.
- X-free outputs after the first reset edge. Outputs are undefined before the first reset.

Test Plan:
- Reset then read
  - Stimulus: hold rst_n=0 for 2 edges, then read addresses 0, 5 and 31, plus HI and LO.
  - Required response: all return 32'h0.
- Write then read
  - Stimulus: write 32'hDEADBEEF to r5, then next cycle read r5 on port 1 and r6 on port 2.
  - Required response: port 1 = DEADBEEF, port 2 = 0.
- Bypass
  - Stimulus: in the same cycle write 32'h12345678 to r9 and read r9 on both ports.
  - Required response: both ports = 12345678 before the edge, and they hold that value after the edge.
  - Repeat with BYPASS_EN=0: ports read the old value 0 until after the edge.
- r0 protection
  - Stimulus: write 32'hFFFFFFFF to address 0 with reg_write_en_w=1, reading address 0 in the same and the next cycle.
  - Required response: read data is 0 throughout.
- HI/LO together with GPR
  - Stimulus: in one cycle write HI=32'h00000001, LO=32'h80000000 and r31=32'hCAFEF00D.
  - Required response: same-cycle bypass shows all three values; after the edge, stored values match; a subsequent write with hilo_write_en_w=0 leaves HI and LO unchanged.
- Reset collides with write
  - Stimulus: after loading r7=32'hA5A5A5A5, assert rst_n=0 in the same cycle as a write of 32'h11111111 to r7.
  - Required response: during that cycle r7 reads A5A5A5A5 with no bypass; after the edge r7 reads 0, and the write is lost.
